// File: rtl/tft_pic_pkg.sv
// Shared TFT picture definitions: display/picture geometry,
// ROM sizing and the per-axis bounce direction type.
package tft_pic_pkg;

    localparam int H_VALID   = 480;
    localparam int V_VALID   = 272;
    localparam int PIC_W     = 100;
    localparam int PIC_H     = 100;
    localparam int STEP      = 2;
    localparam int ROM_DEPTH = PIC_W * PIC_H;
    localparam int ADDR_W    = 14;

    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_t;

endpackage

// File: rtl/tft_axis_bounce.sv
// One-axis bouncing position: moves by STEP per update between 0 and limit.
// Ports: clk, rst (sync high), update, limit, pos, dir.
module tft_axis_bounce
    import tft_pic_pkg::*;
#(
    parameter int STEP = tft_pic_pkg::STEP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       update,
    input  logic [9:0] limit,
    output logic [9:0] pos,
    output dir_t       dir
);

    logic [10:0] pos_ext;
    logic [10:0] pos_inc;
    logic [9:0]  pos_nxt;
    dir_t        dir_nxt;

    // 11-bit intermediates keep pos+STEP from wrapping
    always_comb begin
        pos_ext = {1'b0, pos};
        pos_inc = pos_ext + 11'(STEP);
        pos_nxt = pos;
        dir_nxt = dir;
        unique case (dir)
            DIR_INC: begin
                if (pos_inc >= {1'b0, limit}) begin
                    pos_nxt = limit;
                    dir_nxt = DIR_DEC;
                end else begin
                    pos_nxt = pos_inc[9:0];
                end
            end
            DIR_DEC: begin
                if (pos_ext <= 11'(STEP)) begin
                    pos_nxt = '0;
                    dir_nxt = DIR_INC;
                end else begin
                    pos_nxt = pos - 10'(STEP);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos <= '0;
            dir <= DIR_INC;
        end else if (update) begin
            pos <= pos_nxt;
            dir <= dir_nxt;
        end
    end

endmodule

// File: rtl/tft_pic_move_ctrl.sv
// Bouncing picture controller: ROM read/address for pixels inside the
// picture, and per-frame picture movement.
// Ports: sys_clk, sys_rst, frame_end, move_en, pix_req, pix_x, pix_y in;
//        rom_rd_en, rom_addr, in_pic, pic_x, pic_y out.
module tft_pic_move_ctrl
    import tft_pic_pkg::*;
#(
    parameter int H_VALID = tft_pic_pkg::H_VALID,
    parameter int V_VALID = tft_pic_pkg::V_VALID,
    parameter int PIC_W   = tft_pic_pkg::PIC_W,
    parameter int PIC_H   = tft_pic_pkg::PIC_H,
    parameter int STEP    = tft_pic_pkg::STEP
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        frame_end,
    input  logic        move_en,
    input  logic        pix_req,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    output logic        rom_rd_en,
    output logic [13:0] rom_addr,
    output logic        in_pic,
    output logic [9:0]  pic_x,
    output logic [9:0]  pic_y
);

    localparam logic [9:0]  X_LIM     = 10'(H_VALID - PIC_W);
    localparam logic [9:0]  Y_LIM     = 10'(V_VALID - PIC_H);
    localparam logic [13:0] ADDR_LAST = 14'(PIC_W * PIC_H - 1);

    logic        update;
    logic        hit;
    logic [10:0] x_hi;
    logic [10:0] y_hi;
    dir_t        dir_x;
    dir_t        dir_y;
    logic        unused_dir;

    assign update     = frame_end & move_en;
    assign unused_dir = ^{dir_x, dir_y};

    // window test against the registered position, so a coincident
    // frame_end still sees the old picture location
    always_comb begin
        x_hi = {1'b0, pic_x} + 11'(PIC_W - 1);
        y_hi = {1'b0, pic_y} + 11'(PIC_H - 1);
        hit  = pix_req
            && (pix_x >= pic_x) && ({1'b0, pix_x} <= x_hi)
            && (pix_y >= pic_y) && ({1'b0, pix_y} <= y_hi);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rom_rd_en <= 1'b0;
            in_pic    <= 1'b0;
            rom_addr  <= '0;
        end else begin
            rom_rd_en <= hit;
            in_pic    <= rom_rd_en;
            if (frame_end) begin
                rom_addr <= '0;
            end else if (rom_rd_en) begin
                rom_addr <= (rom_addr == ADDR_LAST) ? '0 : rom_addr + 14'd1;
            end
        end
    end

    tft_axis_bounce #(.STEP(STEP)) u_axis_x (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .update (update),
        .limit  (X_LIM),
        .pos    (pic_x),
        .dir    (dir_x)
    );

    tft_axis_bounce #(.STEP(STEP)) u_axis_y (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .update (update),
        .limit  (Y_LIM),
        .pos    (pic_y),
        .dir    (dir_y)
    );

endmodule

// File: doc/tft_pic_move_ctrl.md
TFT_PIC_MOVE_CTRL -- requirements
Module: tft_pic_move_ctrl

Interface
REQ-001 SHALL provide parameters (name, default, meaning): H_VALID, 480, active pixels per line; V_VALID, 272, active lines per frame; PIC_W, 100, picture width; PIC_H, 100, picture height; STEP, 2, pixels moved per axis per frame.
REQ-002 SHALL have one clock; reset is synchronous and active-high; ports named sys_clk and sys_rst.
REQ-003 Ports (name, direction, width, meaning):
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous active-high reset
- frame_end  in  1  one-cycle pulse from TFT timing after last active pixel of a frame
- move_en  in  1  high = picture moves; low = picture frozen
- pix_req  in  1  timing block requests data for (pix_x, pix_y)
- pix_x  in  10  requested pixel column, valid with pix_req
- pix_y  in  10  requested pixel row, valid with pix_req
- rom_rd_en  out  1  picture ROM read enable
- rom_addr  out  14  picture ROM address, raster order within picture
- in_pic  out  1  high when the ROM data on the bus belongs to the current pixel
- pic_x  out  10  current picture top-left column
- pic_y  out  10  current picture top-left row

Function
REQ-004 hit SHALL be pix_req AND pic_x <= pix_x <= pic_x+PIC_W-1 AND pic_y <= pix_y <= pic_y+PIC_H-1, evaluated against the registered position.
REQ-005 rom_rd_en SHALL be registered hit, asserted the cycle after the pix_req cycle (latency 1).
REQ-006 rom_addr SHALL be a counter presented with rom_rd_en; it advances by 1 after each cycle rom_rd_en is high, and wraps from PIC_W*PIC_H-1 to 0.
REQ-007 rom_addr SHALL clear to 0 on frame_end; clear overrides the increment in the same cycle.
REQ-008 in_pic SHALL be rom_rd_en delayed one cycle (latency 2 from pix_req), aligned with ROM output; the timing block issues pix_req 2 cycles ahead of display.
REQ-009 pic_x/pic_y SHALL update only on cycles with frame_end=1 and move_en=1; otherwise they hold.
REQ-010 Each axis SHALL hold a direction flag (INC/DEC) and a limit LIM (x: H_VALID-PIC_W=380; y: V_VALID-PIC_H=172).
REQ-011 INC: if pos+STEP >= LIM then pos <= LIM and dir <= DEC, else pos <= pos+STEP.
REQ-012 DEC: if pos <= STEP then pos <= 0 and dir <= INC, else pos <= pos-STEP.
REQ-013 The X and Y axes SHALL update independently in the same frame_end cycle.
REQ-014 If pix_req and frame_end coincide, hit SHALL use the old position; the new position applies from the next cycle.
REQ-015 Arithmetic SHALL use 11-bit intermediates so pos+STEP and pos+PIC_W-1 never overflow.
REQ-016 move_en low SHALL freeze position and direction; address generation continues.

Reset
REQ-017 On sys_rst=1 at a clock edge, all of the following SHALL be forced:
- pic_x=0, pic_y=0
- both directions INC
- rom_addr=0, rom_rd_en=0, in_pic=0
REQ-018 Reset SHALL override frame_end and pix_req in the same cycle.
REQ-019 Reset mid-frame SHALL abandon the frame; outputs SHALL stay at reset values until the first pix_req after release.

Structure
REQ-020 Package tft_pic_pkg SHALL hold the following shared definitions, used by this block and the TFT timing/top blocks:
- H_VALID, V_VALID, PIC_W, PIC_H, STEP
- ROM_DEPTH = PIC_W*PIC_H, ADDR_W = 14
- direction enum {DIR_INC, DIR_DEC}
REQ-021 Sub-module tft_axis_bounce SHALL implement REQ-011/012 for one axis (ports: clock, reset, update, limit, pos, dir) and be instantiated twice.

Verification
REQ-022 Reset, then pix_req at (0,0)..(99,0) contiguous:
- rom_rd_en high 100 cycles starting 1 cycle later, addresses 0..99
- in_pic high 1 cycle after rom_rd_en
REQ-023 Reset, move_en=1, 86 frame_end pulses:
- pic_y=172, dir_y=DEC, pic_x=172
- 87th pulse: pic_y=170, pic_x=174
REQ-024 Continue to 190 total pulses:
- pic_x=380, dir_x=DEC
- 191st pulse: pic_x=378
REQ-025 move_en=0 with 10 frame_end pulses: pic_x/pic_y unchanged; then pix_req in the picture region still yields correct rom_addr.
REQ-026 pix_req and frame_end in the same cycle at pixel (pic_x,pic_y):
- rom_rd_en=1 next cycle with rom_addr=0
- position advanced by STEP
REQ-027 Full frame at pic=(0,0): exactly 10000 rom_rd_en cycles, last address 9999; sys_rst asserted mid-frame gives rom_rd_en=0 and rom_addr=0 the next cycle.
